// File: rtl/ex_hilo_stage_if.sv
// ----------------------------------------------------------------------------
// ex_hilo_stage_if
// Purpose : bundles the decode-side operation fields, pipeline control and the
//           registered MEM-side result fields of the execute stage.
// Signals :
//   stall_i, flush_i           pipeline control (freeze / bubble the input latch)
//   aluop_i, alusel_i          decoded operation and result class
//   reg1_i, reg2_i             forwarded operands
//   wd_i, wreg_i               destination GPR and its write enable
//   wd_o, wreg_o, wdata_o      registered GPR write toward MEM
//   whilo_o, hi_o, lo_o        registered HI/LO write toward commit
//   hi_arch_o, lo_arch_o       committed HI/LO (debug visibility)
// Modports: master = decode/MEM side, slave = execute stage.
// ----------------------------------------------------------------------------
interface ex_hilo_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hi_arch_o;
    logic [31:0] lo_arch_o;

    modport master (
        output stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, hi_arch_o, lo_arch_o
    );

    modport slave (
        input  stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, hi_arch_o, lo_arch_o
    );
endinterface

// File: rtl/ex_hilo_stage.sv
// ----------------------------------------------------------------------------
// ex_hilo_stage
// Purpose : execute stage of the integer pipeline. Latches the decoded
//           operation (L), computes logic / shift / move results into the
//           output register (R) and owns the architectural HI/LO registers,
//           which commit from R one cycle after the result leaves the stage.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous, active-low reset (clears L, R, HI, LO)
//   bus   ex_hilo_stage_if.slave - decode inputs, stall/flush, MEM outputs
// Build option:
//   HILO_BYPASS_EN  when defined, "current HI/LO" is taken from R if R holds a
//                   pending HI/LO write, otherwise from the committed registers.
//                   When undefined, only the committed registers are read and
//                   software must space MFHI/MFLO/MTxx after an MTHI/MTLO.
// ----------------------------------------------------------------------------
module ex_hilo_stage (
    input  logic           clk,
    input  logic           rst,
    ex_hilo_stage_if.slave bus
);
    // Operation encodings shared with decode.
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    // Input latch L
    logic [7:0]  r_aluop;
    logic [2:0]  r_alusel;
    logic [31:0] r_reg1;
    logic [31:0] r_reg2;
    logic [4:0]  r_wd;
    logic        r_wreg;

    // Output register R
    logic [4:0]  r_wd_out;
    logic        r_wreg_out;
    logic [31:0] r_wdata;
    logic        r_whilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Architectural HI/LO
    logic [31:0] r_hi_arch;
    logic [31:0] r_lo_arch;

    // Combinational next-R values
    logic [31:0] w_cur_hi;
    logic [31:0] w_cur_lo;
    logic [4:0]  w_amt;
    logic [31:0] w_wdata_next;
    logic        w_whilo_next;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;

`ifdef HILO_BYPASS_EN
    // A pending write in R is the youngest HI/LO value; it commits on the same
    // edge that R loads the instruction now in L, so forwarding it is exact.
    assign w_cur_hi = r_whilo ? r_hi : r_hi_arch;
    assign w_cur_lo = r_whilo ? r_lo : r_lo_arch;
`else
    assign w_cur_hi = r_hi_arch;
    assign w_cur_lo = r_lo_arch;
`endif

    assign w_amt = r_reg1[4:0];

    always_comb begin
        w_wdata_next = 32'h0;
        case (r_alusel)
            SEL_LOGIC: begin
                case (r_aluop)
                    OP_OR:   w_wdata_next = r_reg1 | r_reg2;
                    OP_AND:  w_wdata_next = r_reg1 & r_reg2;
                    OP_XOR:  w_wdata_next = r_reg1 ^ r_reg2;
                    OP_NOR:  w_wdata_next = ~(r_reg1 | r_reg2);
                    default: w_wdata_next = 32'h0;
                endcase
            end
            SEL_SHIFT: begin
                case (r_aluop)
                    OP_SLL:  w_wdata_next = r_reg2 << w_amt;
                    OP_SRL:  w_wdata_next = r_reg2 >> w_amt;
                    OP_SRA:  w_wdata_next = $signed(r_reg2) >>> w_amt;
                    default: w_wdata_next = 32'h0;
                endcase
            end
            SEL_MOVE: begin
                case (r_aluop)
                    OP_MOVZ, OP_MOVN: w_wdata_next = r_reg1;
                    OP_MFHI:          w_wdata_next = w_cur_hi;
                    OP_MFLO:          w_wdata_next = w_cur_lo;
                    default:          w_wdata_next = 32'h0;
                endcase
            end
            default: w_wdata_next = 32'h0;
        endcase
    end

    // HI/LO write request depends only on the operation, not the result class.
    always_comb begin
        w_whilo_next = 1'b0;
        w_hi_next    = w_cur_hi;
        w_lo_next    = w_cur_lo;
        if (r_aluop == OP_MTHI) begin
            w_whilo_next = 1'b1;
            w_hi_next    = r_reg1;
        end else if (r_aluop == OP_MTLO) begin
            w_whilo_next = 1'b1;
            w_lo_next    = r_reg1;
        end
    end

    // Input latch: flush wins over stall so a squashed instruction never
    // lingers in L while the rest of the stage is frozen.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush_i) begin
            r_aluop  <= 8'h0;
            r_alusel <= 3'h0;
            r_reg1   <= 32'h0;
            r_reg2   <= 32'h0;
            r_wd     <= 5'h0;
            r_wreg   <= 1'b0;
        end else if (!bus.stall_i) begin
            r_aluop  <= bus.aluop_i;
            r_alusel <= bus.alusel_i;
            r_reg1   <= bus.reg1_i;
            r_reg2   <= bus.reg2_i;
            r_wd     <= bus.wd_i;
            r_wreg   <= bus.wreg_i;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd_out   <= 5'h0;
            r_wreg_out <= 1'b0;
            r_wdata    <= 32'h0;
            r_whilo    <= 1'b0;
            r_hi       <= 32'h0;
            r_lo       <= 32'h0;
        end else if (!bus.stall_i) begin
            r_wd_out   <= r_wd;
            r_wreg_out <= r_wreg;
            r_wdata    <= w_wdata_next;
            r_whilo    <= w_whilo_next;
            r_hi       <= w_hi_next;
            r_lo       <= w_lo_next;
        end
    end

    // Commit: gated by stall as well, so a held R commits exactly once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi_arch <= 32'h0;
            r_lo_arch <= 32'h0;
        end else if (!bus.stall_i && r_whilo) begin
            r_hi_arch <= r_hi;
            r_lo_arch <= r_lo;
        end
    end

    assign bus.wd_o      = r_wd_out;
    assign bus.wreg_o    = r_wreg_out;
    assign bus.wdata_o   = r_wdata;
    assign bus.whilo_o   = r_whilo;
    assign bus.hi_o      = r_hi;
    assign bus.lo_o      = r_lo;
    assign bus.hi_arch_o = r_hi_arch;
    assign bus.lo_arch_o = r_lo_arch;

endmodule

// File: tb/tb_ex_hilo_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_hilo_stage
// Self-checking bench for ex_hilo_stage: directed vector table, hand-written
// HI/LO / stall / flush / reset sequences, and a randomized run compared
// against a program-order reference model. Works with or without
// HILO_BYPASS_EN defined.
// ----------------------------------------------------------------------------
module tb_ex_hilo_stage;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;

`ifdef HILO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    ex_hilo_stage_if bus ();

    ex_hilo_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic        wreg;
    } inst_t;

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    typedef struct {
        string       name;
        inst_t       in;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input inst_t i);
        bus.aluop_i  = i.op;
        bus.alusel_i = i.sel;
        bus.reg1_i   = i.a;
        bus.reg2_i   = i.b;
        bus.wd_i     = i.wd;
        bus.wreg_i   = i.wreg;
    endtask

    function automatic inst_t mk(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wreg);
        inst_t i;
        i.op = op; i.sel = sel; i.a = a; i.b = b; i.wd = wd; i.wreg = wreg;
        return i;
    endfunction

    function automatic inst_t nop();
        return mk(OP_NOP, 3'b000, 32'h0, 32'h0, 5'h0, 1'b0);
    endfunction

    // ---------------- reference model (program-order HI/LO) ----------------
    // prog_*: HI/LO after every instruction that has entered R.
    // arch_*: the same, excluding the one still sitting in R (not yet committed).
    inst_t       m_l;
    res_t        m_r;
    logic [31:0] prog_hi, prog_lo, arch_hi, arch_lo;

    function automatic res_t exec(input inst_t i, input logic [31:0] ch, input logic [31:0] cl);
        res_t r;
        int   amt;
        amt     = int'(i.a % 32);
        r.wd    = i.wd;
        r.wreg  = i.wreg;
        r.wdata = 32'h0;
        r.whilo = 1'b0;
        r.hi    = ch;
        r.lo    = cl;
        if (i.sel == 3'b001) begin
            if (i.op == OP_OR)  r.wdata = i.a | i.b;
            if (i.op == OP_AND) r.wdata = i.a & i.b;
            if (i.op == OP_XOR) r.wdata = i.a ^ i.b;
            if (i.op == OP_NOR) r.wdata = ~(i.a | i.b);
        end else if (i.sel == 3'b010) begin
            if (i.op == OP_SLL) r.wdata = i.b << amt;
            if (i.op == OP_SRL) r.wdata = i.b >> amt;
            if (i.op == OP_SRA) r.wdata = i.b[31] ? ~((~i.b) >> amt) : (i.b >> amt);
        end else if (i.sel == 3'b011) begin
            if (i.op == OP_MOVZ || i.op == OP_MOVN) r.wdata = i.a;
            if (i.op == OP_MFHI) r.wdata = ch;
            if (i.op == OP_MFLO) r.wdata = cl;
        end
        if (i.op == OP_MTHI) begin r.whilo = 1'b1; r.hi = i.a; end
        if (i.op == OP_MTLO) begin r.whilo = 1'b1; r.lo = i.a; end
        return r;
    endfunction

    task automatic model_reset();
        m_l = nop();
        m_r = '{32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        prog_hi = 0; prog_lo = 0; arch_hi = 0; arch_lo = 0;
    endtask

    task automatic model_step(input logic r_n, input logic st, input logic fl, input inst_t in);
        res_t nr;
        if (!r_n) begin
            model_reset();
            return;
        end
        if (!st) begin
            nr = BYPASS ? exec(m_l, prog_hi, prog_lo) : exec(m_l, arch_hi, arch_lo);
            arch_hi = prog_hi;
            arch_lo = prog_lo;
            if (nr.whilo) begin
                prog_hi = nr.hi;
                prog_lo = nr.lo;
            end
            m_r = nr;
        end
        if (fl)       m_l = nop();
        else if (!st) m_l = in;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".wdata"},   bus.wdata_o,          m_r.wdata);
        chk({tag, ".wd"},      32'(bus.wd_o),        32'(m_r.wd));
        chk({tag, ".wreg"},    32'(bus.wreg_o),      32'(m_r.wreg));
        chk({tag, ".whilo"},   32'(bus.whilo_o),     32'(m_r.whilo));
        chk({tag, ".hi"},      bus.hi_o,             m_r.hi);
        chk({tag, ".lo"},      bus.lo_o,             m_r.lo);
        chk({tag, ".hi_arch"}, bus.hi_arch_o,        arch_hi);
        chk({tag, ".lo_arch"}, bus.lo_arch_o,        arch_lo);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(nop());
        tick();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".wdata"},   bus.wdata_o,      32'h0);
        chk({tag, ".wd"},      32'(bus.wd_o),    32'h0);
        chk({tag, ".wreg"},    32'(bus.wreg_o),  32'h0);
        chk({tag, ".whilo"},   32'(bus.whilo_o), 32'h0);
        chk({tag, ".hi"},      bus.hi_o,         32'h0);
        chk({tag, ".lo"},      bus.lo_o,         32'h0);
        chk({tag, ".hi_arch"}, bus.hi_arch_o,    32'h0);
        chk({tag, ".lo_arch"}, bus.lo_arch_o,    32'h0);
    endtask

    vec_t vecs[13];
    inst_t rops[13];

    initial begin
        // -------- vector table --------
        vecs[0]  = '{"or",      mk(OP_OR,  3'b001, 32'h0000F0F0, 32'h00FF00FF, 5'd3,  1'b1), 32'h00FFF0FF};
        vecs[1]  = '{"sra",     mk(OP_SRA, 3'b010, 32'd4,        32'h80000010, 5'd5,  1'b1), 32'hF8000001};
        vecs[2]  = '{"srl",     mk(OP_SRL, 3'b010, 32'd4,        32'h80000010, 5'd6,  1'b1), 32'h08000001};
        vecs[3]  = '{"sll",     mk(OP_SLL, 3'b010, 32'd36,       32'h80000010, 5'd7,  1'b1), 32'h00000100};
        vecs[4]  = '{"and",     mk(OP_AND, 3'b001, 32'hFF00FF00, 32'h0FF00FF0, 5'd8,  1'b1), 32'h0F000F00};
        vecs[5]  = '{"xor",     mk(OP_XOR, 3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 5'd9,  1'b0), 32'hF0F00F0F};
        vecs[6]  = '{"nor",     mk(OP_NOR, 3'b001, 32'h0000FFFF, 32'h00FF0000, 5'd10, 1'b1), 32'hFF000000};
        vecs[7]  = '{"movz",    mk(OP_MOVZ,3'b011, 32'hCAFEBABE, 32'h0,        5'd11, 1'b1), 32'hCAFEBABE};
        vecs[8]  = '{"nop",     mk(OP_NOP, 3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd12, 1'b1), 32'h0};
        vecs[9]  = '{"badsel",  mk(OP_OR,  3'b111, 32'hFFFFFFFF, 32'h1,        5'd13, 1'b1), 32'h0};
        vecs[10] = '{"sra_a0",  mk(OP_SRA, 3'b010, 32'd32,       32'h80000000, 5'd14, 1'b1), 32'h80000000};
        vecs[11] = '{"srl_a31", mk(OP_SRL, 3'b010, 32'd31,       32'h80000000, 5'd15, 1'b1), 32'h00000001};
        vecs[12] = '{"sra_a31", mk(OP_SRA, 3'b010, 32'd31,       32'h80000000, 5'd31, 1'b1), 32'hFFFFFFFF};

        rops[0]  = mk(OP_OR,   3'b001, 0, 0, 0, 1);
        rops[1]  = mk(OP_AND,  3'b001, 0, 0, 0, 1);
        rops[2]  = mk(OP_XOR,  3'b001, 0, 0, 0, 1);
        rops[3]  = mk(OP_NOR,  3'b001, 0, 0, 0, 1);
        rops[4]  = mk(OP_SLL,  3'b010, 0, 0, 0, 1);
        rops[5]  = mk(OP_SRL,  3'b010, 0, 0, 0, 1);
        rops[6]  = mk(OP_SRA,  3'b010, 0, 0, 0, 1);
        rops[7]  = mk(OP_MOVN, 3'b011, 0, 0, 0, 1);
        rops[8]  = mk(OP_MFHI, 3'b011, 0, 0, 0, 1);
        rops[9]  = mk(OP_MFLO, 3'b011, 0, 0, 0, 1);
        rops[10] = mk(OP_MTHI, 3'b000, 0, 0, 0, 0);
        rops[11] = mk(OP_MTLO, 3'b000, 0, 0, 0, 0);
        rops[12] = mk(OP_NOP,  3'b000, 0, 0, 0, 0);

        // -------- reset state --------
        do_reset();
        check_all_zero("reset");
        $display("reset: all outputs checked");

        // -------- table-driven vectors --------
        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].in);
            tick();
            drive(nop());
            tick();
            chk({vecs[k].name, ".wdata"}, bus.wdata_o,       vecs[k].exp);
            chk({vecs[k].name, ".wd"},    32'(bus.wd_o),     32'(vecs[k].in.wd));
            chk({vecs[k].name, ".wreg"},  32'(bus.wreg_o),   32'(vecs[k].in.wreg));
            chk({vecs[k].name, ".whilo"}, 32'(bus.whilo_o),  32'h0);
            $display("vec %s: wdata=0x%08h", vecs[k].name, bus.wdata_o);
        end

        // -------- MTHI then MFHI on the next cycle --------
        do_reset();
        drive(mk(OP_MTHI, 3'b000, 32'h12345678, 0, 0, 0));
        tick();
        drive(mk(OP_MFHI, 3'b011, 0, 0, 5'd2, 1));
        tick();
        chk("mthi.whilo", 32'(bus.whilo_o), 32'h1);
        chk("mthi.hi_o",  bus.hi_o, 32'h12345678);
        drive(nop());
        tick();
        chk("mfhi_adj.wdata", bus.wdata_o, BYPASS ? 32'h12345678 : 32'h0);
        chk("mthi.hi_arch",   bus.hi_arch_o, 32'h12345678);
        $display("mthi->mfhi adjacent: wdata=0x%08h", bus.wdata_o);

        // MFHI with two independent instructions in between sees the new value
        do_reset();
        drive(mk(OP_MTHI, 3'b000, 32'h12345678, 0, 0, 0));
        tick();
        drive(nop()); tick();
        drive(nop()); tick();
        drive(mk(OP_MFHI, 3'b011, 0, 0, 5'd2, 1));
        tick();
        drive(nop());
        tick();
        chk("mfhi_sep.wdata", bus.wdata_o, 32'h12345678);
        $display("mthi->mfhi separated: wdata=0x%08h", bus.wdata_o);

        // Back-to-back MTHI/MTLO
        do_reset();
        drive(mk(OP_MTHI, 3'b000, 32'h11112222, 0, 0, 0)); tick();
        drive(mk(OP_MTLO, 3'b000, 32'h33334444, 0, 0, 0)); tick();
        drive(nop()); tick();
        drive(nop()); tick();
        chk("b2b.lo_arch", bus.lo_arch_o, 32'h33334444);
        chk("b2b.hi_arch", bus.hi_arch_o, BYPASS ? 32'h11112222 : 32'h0);
        $display("mthi/mtlo back-to-back: hi=0x%08h lo=0x%08h", bus.hi_arch_o, bus.lo_arch_o);

        // -------- stall with MTLO in R --------
        do_reset();
        drive(mk(OP_MTLO, 3'b000, 32'hA5A5A5A5, 0, 0, 0));
        tick();
        drive(nop());
        tick();
        bus.stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall.whilo",   32'(bus.whilo_o), 32'h1);
            chk("stall.lo_o",    bus.lo_o, 32'hA5A5A5A5);
            chk("stall.lo_arch", bus.lo_arch_o, 32'h0);
        end
        bus.stall_i = 1'b0;
        tick();
        chk("unstall.lo_arch", bus.lo_arch_o, 32'hA5A5A5A5);
        chk("unstall.whilo",   32'(bus.whilo_o), 32'h0);
        $display("stall: lo_arch=0x%08h after release", bus.lo_arch_o);

        // -------- flush coinciding with MTHI in decode --------
        do_reset();
        drive(mk(OP_OR, 3'b001, 32'h000000F0, 32'h0000000F, 5'd7, 1));
        tick();
        drive(mk(OP_MTHI, 3'b000, 32'hDEADBEEF, 0, 0, 0));
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush.wdata", bus.wdata_o, 32'h000000FF);
        chk("flush.wd",    32'(bus.wd_o), 32'd7);
        drive(nop());
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("flush.whilo",   32'(bus.whilo_o), 32'h0);
            chk("flush.hi_arch", bus.hi_arch_o, 32'h0);
        end
        $display("flush: hi_arch=0x%08h", bus.hi_arch_o);

        // -------- stall and flush together --------
        do_reset();
        drive(mk(OP_XOR, 3'b001, 32'h0000000F, 32'h000000F0, 5'd9, 1)); tick();
        drive(mk(OP_OR,  3'b001, 32'h1, 32'h2, 5'd4, 1)); tick();
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        chk("stfl.wdata", bus.wdata_o, 32'h000000FF);
        chk("stfl.wd",    32'(bus.wd_o), 32'd9);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(nop());
        tick();
        chk("stfl_rel.wdata", bus.wdata_o, 32'h0);
        chk("stfl_rel.wd",    32'(bus.wd_o), 32'h0);
        $display("stall+flush: wdata=0x%08h wd=%0d", bus.wdata_o, bus.wd_o);

        // -------- reset while MTLO is in R --------
        do_reset();
        drive(mk(OP_MTLO, 3'b000, 32'h55AA55AA, 0, 0, 0)); tick();
        drive(nop()); tick();
        chk("rstmid.pre_whilo", 32'(bus.whilo_o), 32'h1);
        rst = 1'b0;
        bus.stall_i = 1'b1;
        tick();
        rst = 1'b1;
        bus.stall_i = 1'b0;
        check_all_zero("rstmid");
        tick();
        chk("rstmid.lo_arch_after", bus.lo_arch_o, 32'h0);
        $display("reset mid-sequence: lo_arch=0x%08h", bus.lo_arch_o);

        // -------- randomized run against the reference model --------
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            inst_t  in;
            logic   r_n, st, fl;
            in      = rops[$urandom_range(12)];
            in.a    = $urandom();
            in.b    = $urandom();
            in.wd   = 5'($urandom_range(31));
            if ($urandom_range(3) == 0) in.a = 32'($urandom_range(40));
            r_n = ($urandom_range(49) != 0);
            st  = ($urandom_range(9) == 0);
            fl  = ($urandom_range(9) == 0);
            drive(in);
            rst = r_n;
            bus.stall_i = st;
            bus.flush_i = fl;
            tick();
            model_step(r_n, st, fl, in);
            compare_all("rand");
            $display("rand %0d: op=%02h rst=%0b st=%0b fl=%0b wdata=0x%08h hi_arch=0x%08h lo_arch=0x%08h",
                     c, in.op, r_n, st, fl, bus.wdata_o, bus.hi_arch_o, bus.lo_arch_o);
        end
        rst = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
